hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Load-use hazard detection unit for the 5-stage MIPS pipeline. It drives the stall-select input of the ID/EX control-zeroing mux, and the PC and IF/ID write enables.
It keeps its own shadow copy of the load destination registers in EX and MEM. From these it decides stalls without reading the ID/EX or EX/MEM pipeline registers.
It sits beside the ID stage: instruction fields come in from the decoder, and stall/enable signals go out to the PC, IF/ID and the ID/EX control mux.

Parameters:
LOAD_BUBBLES, 1, bubbles inserted per load-use hazard. 1 = full EX/MEM/WB forwarding present; 2 = no MEM-stage forwarding. Only 1 and 2 are legal.
REG_W, 5, register-index width.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction (0 = bubble)
id_rs  in  REG_W  rs field of the instruction in ID
id_rt  in  REG_W  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
id_memread  in  1  ID instruction is a load (MemRead from the main control)
flush  in  1  branch taken; the ID instruction is squashed this cycle
stall_choose  out  1  1 = ID/EX control mux forces all controls to 0 (bubble)
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID register load enable
stall_cycles  out  2  bubbles still owed to the current hazard (0..LOAD_BUBBLES)

Behaviour:
- Shadow state. Each stage holds a load flag and a destination register:
  - EX stage: ex_load, ex_rd.
  - MEM stage: mem_load, mem_rd. Present only when LOAD_BUBBLES=2; otherwise tied to 0.
- Reset (rst_n=0, async): all shadow flops are 0.
  - Resulting outputs: stall_choose=0, pc_write=1, ifid_write=1, stall_cycles=0.
- Match terms (combinational):
  - match_ex = ex_load & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt))
  - match_mem uses the same equation with the mem_* flops.
- Stall condition: hazard = id_valid & ~flush & (match_ex | (LOAD_BUBBLES==2 & match_mem)).
- Outputs:
  - stall_choose = hazard.
  - pc_write = ifid_write = ~hazard.
  - Outputs are combinational with the same-cycle response required; there is zero latency from ID fields to the stall.
- stall_cycles:
  - LOAD_BUBBLES=2: 2 if match_ex, else 1 if match_mem, else 0.
  - LOAD_BUBBLES=1: 1 if match_ex, else 0.
  - Forced to 0 when hazard=0.
- Shadow update on each rising clk:
  - If hazard or flush or ~id_valid: ex_load<=0, ex_rd<=0 (a bubble enters EX).
  - Otherwise: ex_load<=id_memread, ex_rd<=id_rt.
  - Always: mem_load<=ex_load, mem_rd<=ex_rd.
- Required timing: a load followed immediately by a dependent instruction stalls exactly LOAD_BUBBLES cycles.
  - Cycle after the load: match_ex stalls.
  - With LOAD_BUBBLES=2, the following cycle: match_mem stalls.
  - Next cycle: load is in WB (register file is write-before-read), so no stall.
- Dependent instruction two slots behind the load: stalls LOAD_BUBBLES-1 cycles.
- Destination $0 never causes a stall.
- flush and hazard in the same cycle: flush wins. No stall, and the bubble enters EX.
- Reset asserted mid-stall: stall drops asynchronously and shadow state clears. No hazard carries over after reset.
- Back-to-back loads where the second depends on the first: the second is stalled like any other consumer. After it issues, it becomes the new ex_load.

Optional Feature:
STALL_PERF_CNT_EN.
- Defined: adds output bubble_count (32 bits).
  - Increments by 1 on every clk edge where hazard=1; wraps at 2^32-1 to 0.
  - Reset value 0.
  - Adds input perf_clr (1 bit), a synchronous clear that takes priority over increment.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - REG_W.
  - Localparam REG_ZERO=0.
  - Typedef for a load-tracking entry {load, rd}, used for both the EX and MEM shadow stages.
- One natural sub-module: load_dep_cmp.
  - Purely combinational.
  - Takes one tracking entry plus id_rs/id_rt/id_uses_rt and returns match.
  - Instantiated once per tracked stage.

Test Plan:
1. LOAD_BUBBLES=1: `lw $8` then `add $9,$8,$10` (rs=8) → stall_choose=1, pc_write=0, stall_cycles=1 for exactly 1 cycle, then 0; ex_load=0 after the bubble.
2. LOAD_BUBBLES=2: same sequence → stall for 2 consecutive cycles with stall_cycles 2 then 1, then released.
3. `lw $0`, then `add` using $0 → no stall. `lw $8`, then `sw` with rt=8 and id_uses_rt=1 → stall. `lw $8`, then `addi` with rt=8 and id_uses_rt=0 → no stall.
4. `lw $8`, then a dependent `add` with flush=1 in the same cycle → stall_choose=0, pc_write=1; the next cycle shows no residual stall.
5. Assert rst_n=0 during the 2nd bubble (LOAD_BUBBLES=2) → outputs are immediately 0/1/1/0; after release, a non-dependent instruction gets no stall.
6. STALL_PERF_CNT_EN defined: 3 load-use hazards at LOAD_BUBBLES=2 → bubble_count=6; then perf_clr → 0. Preload 32'hFFFFFFFF then one bubble → wraps to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard logic.
//   REG_W       register-index width
//   REG_ZERO    index of the hard-wired zero register ($0)
//   loadEntry_t one shadow tracking entry {load, rd}, used for EX and MEM
package pipe_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic             load;
    logic [REG_W-1:0] rd;
  } loadEntry_t;
endpackage

// File: rtl/load_dep_cmp.sv
// Load-use dependency compare for one tracked pipeline stage (combinational).
//   entry    shadow entry {load, rd} of the tracked stage
//   idRs     rs field of the instruction in ID
//   idRt     rt field of the instruction in ID
//   idUsesRt ID instruction actually reads rt
//   match    ID instruction consumes the pending load result of this stage
module load_dep_cmp
  import pipe_pkg::*;
(
  input  loadEntry_t       entry,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRt,
  output logic             match
);
  // A load to $0 writes nothing, so it can never be a producer.
  assign match = entry.load && (entry.rd != REG_ZERO) &&
                 ((entry.rd == idRs) || (idUsesRt && (entry.rd == idRt)));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detection beside the ID stage. Keeps its own shadow of
// load destinations in EX (and MEM when LOAD_BUBBLES=2) and raises a
// same-cycle stall for any ID instruction consuming a pending load.
//   clk, rst_n    pipeline clock, async active-low reset
//   id_*          decoded fields of the instruction in ID
//   flush         branch taken, ID instruction squashed this cycle
//   stall_choose  zero the ID/EX controls (insert bubble)
//   pc_write      PC load enable
//   ifid_write    IF/ID load enable
//   stall_cycles  bubbles still owed to the current hazard
// Optional (macro STALL_PERF_CNT_EN): perf_clr in, bubble_count[31:0] out,
// counting every clock edge on which a bubble is inserted.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int REG_W        = pipe_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_memread,
  input  logic             flush,
`ifdef STALL_PERF_CNT_EN
  input  logic             perf_clr,
  output logic [31:0]      bubble_count,
`endif
  output logic             stall_choose,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [1:0]       stall_cycles
);
  loadEntry_t exEntry, memEntry;
  logic       matchEx, matchMem, hazard;

  load_dep_cmp uCmpEx (
    .entry(exEntry), .idRs(id_rs), .idRt(id_rt), .idUsesRt(id_uses_rt), .match(matchEx)
  );
  load_dep_cmp uCmpMem (
    .entry(memEntry), .idRs(id_rs), .idRt(id_rt), .idUsesRt(id_uses_rt), .match(matchMem)
  );

  // flush wins over a hazard: the squashed instruction needs no bubble.
  assign hazard = id_valid && !flush &&
                  (matchEx || ((LOAD_BUBBLES == 2) && matchMem));

  assign stall_choose = hazard;
  assign pc_write     = !hazard;
  assign ifid_write   = !hazard;

  always_comb begin
    stall_cycles = 2'd0;
    if (hazard) begin
      if (matchEx) stall_cycles = (LOAD_BUBBLES == 2) ? 2'd2 : 2'd1;
      else         stall_cycles = 2'd1;  // only reachable via MEM match
    end
  end

  // A stalled, flushed or empty ID slot sends a bubble into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exEntry <= '0;
    end else if (hazard || flush || !id_valid) begin
      exEntry <= '0;
    end else begin
      exEntry.load <= id_memread;
      exEntry.rd   <= id_rt;
    end
  end

  // The MEM shadow only matters when the MEM stage cannot forward.
  generate
    if (LOAD_BUBBLES == 2) begin : gMem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) memEntry <= '0;
        else        memEntry <= exEntry;
      end
    end else begin : gNoMem
      assign memEntry = '0;
    end
  endgenerate

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bubble_count <= '0;
    else if (perf_clr) bubble_count <= '0;
    else if (hazard)  bubble_count <= bubble_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rt, id_memread, flush;
  logic [4:0] id_rs, id_rt;
  logic       sc1, pw1, iw1, sc2, pw2, iw2;
  logic [1:0] cyc1, cyc2;
`ifdef STALL_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] bc1, bc2;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_BUBBLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_memread(id_memread), .flush(flush),
`ifdef STALL_PERF_CNT_EN
    .perf_clr(perf_clr), .bubble_count(bc1),
`endif
    .stall_choose(sc1), .pc_write(pw1), .ifid_write(iw1), .stall_cycles(cyc1)
  );

  hazard_stall_ctrl #(.LOAD_BUBBLES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_memread(id_memread), .flush(flush),
`ifdef STALL_PERF_CNT_EN
    .perf_clr(perf_clr), .bubble_count(bc2),
`endif
    .stall_choose(sc2), .pc_write(pw2), .ifid_write(iw2), .stall_cycles(cyc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {stall_choose, pc_write, ifid_write, stall_cycles} packed for compact checks
  task automatic chk1(input string tag, input logic [4:0] exp);
    chk({tag, "/lb1"}, {27'd0, sc1, pw1, iw1, cyc1}, {27'd0, exp});
  endtask
  task automatic chk2(input string tag, input logic [4:0] exp);
    chk({tag, "/lb2"}, {27'd0, sc2, pw2, iw2, cyc2}, {27'd0, exp});
  endtask

  localparam logic [4:0] GO   = 5'b0_1_1_00;
  localparam logic [4:0] ST1  = 5'b1_0_0_01;
  localparam logic [4:0] ST2  = 5'b1_0_0_10;

  // Drive ID fields just after a rising edge; outputs settle before sampling.
  task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ur; id_memread = mr; flush = fl;
    #1;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    setId(0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  initial begin
`ifdef STALL_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    rst_n = 1'b0;
    setId(0, 0, 0, 0, 0, 0);
    #12;
    chk1("reset", GO); chk2("reset", GO);
    rst_n = 1'b1;
    step();

    // lw $8 ; add $9,$8,$10
    setId(1, 5'd1, 5'd8, 0, 1, 0);
    chk1("lw_issue", GO); chk2("lw_issue", GO);
    step();
    setId(1, 5'd8, 5'd10, 1, 0, 0);
    chk1("use_b0", ST1); chk2("use_b0", ST2);
    step();
    chk1("use_b1", GO); chk2("use_b1", ST1);
    chk("ex_load_after_bubble", {31'd0, u1.exEntry.load}, 32'd0);
    step();
    chk1("use_b2", GO); chk2("use_b2", GO);
    idle(2);

    // lw $0 then a user of $0: never a hazard
    setId(1, 5'd1, 5'd0, 0, 1, 0); step();
    setId(1, 5'd0, 5'd0, 1, 0, 0);
    chk1("dest0", GO); chk2("dest0", GO);
    idle(2);

    // lw $8 ; sw with rt=8 (reads rt)
    setId(1, 5'd1, 5'd8, 0, 1, 0); step();
    setId(1, 5'd2, 5'd8, 1, 0, 0);
    chk1("sw_rt", ST1); chk2("sw_rt", ST2);
    idle(3);

    // lw $8 ; addi with rt=8 as destination only
    setId(1, 5'd1, 5'd8, 0, 1, 0); step();
    setId(1, 5'd3, 5'd8, 0, 0, 0);
    chk1("addi_rt", GO); chk2("addi_rt", GO);
    idle(3);

    // dependent instruction two slots behind the load
    setId(1, 5'd1, 5'd8, 0, 1, 0); step();
    setId(1, 5'd1, 5'd2, 1, 0, 0); step();
    setId(1, 5'd8, 5'd3, 1, 0, 0);
    chk1("dist2", GO); chk2("dist2", ST1);
    idle(3);

    // flush in the hazard cycle wins
    setId(1, 5'd1, 5'd8, 0, 1, 0); step();
    setId(1, 5'd8, 5'd10, 1, 0, 1);
    chk1("flush", GO); chk2("flush", GO);
    step();
    setId(1, 5'd1, 5'd2, 1, 0, 0);
    chk1("post_flush", GO); chk2("post_flush", GO);
    idle(3);

    // reset during the second bubble (LOAD_BUBBLES=2)
    setId(1, 5'd1, 5'd8, 0, 1, 0); step();
    setId(1, 5'd8, 5'd10, 1, 0, 0); step();
    chk2("pre_rst", ST1);
    rst_n = 1'b0; #1;
    chk2("async_rst", GO);
    chk("rst_ex", {31'd0, u2.exEntry.load}, 32'd0);
    step();
    rst_n = 1'b1;
    setId(1, 5'd8, 5'd10, 1, 0, 0);
    chk1("after_rst", GO); chk2("after_rst", GO);
    idle(3);

    // back-to-back loads, lw $9,0($8) depends on lw $8 (LOAD_BUBBLES=1)
    setId(1, 5'd1, 5'd8, 0, 1, 0); step();
    setId(1, 5'd8, 5'd9, 0, 1, 0);
    chk1("ldld_stall", ST1);
    step();
    chk1("ldld_issue", GO);
    step();
    chk("ldld_ex_rd", {26'd0, u1.exEntry.load, u1.exEntry.rd}, {26'd0, 1'b1, 5'd9});
    setId(1, 5'd9, 5'd4, 1, 0, 0);
    chk1("ldld_use2", ST1);
    idle(3);

`ifdef STALL_PERF_CNT_EN
    perf_clr = 1'b1; step(); perf_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      setId(1, 5'd1, 5'd8, 0, 1, 0); step();
      setId(1, 5'd8, 5'd10, 1, 0, 0); step(); step();
      idle(2);
    end
    chk("perf_lb2", bc2, 32'd6);
    chk("perf_lb1", bc1, 32'd3);
    perf_clr = 1'b1; step(); perf_clr = 1'b0;
    chk("perf_clr", bc2, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected finish before 50000");
    $fatal(1);
  end
endmodule
